sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator directly upstream of sobel_filter.
//  Accepts one WIDTH x HEIGHT frame of pixels in raster order over a valid/ready
//  handshake and emits one 3x3 window per pixel position, in raster order.
//  Borders use replicate-edge padding (out-of-range row/col clamped to nearest
//  edge), so the Sobel stage no longer needs a pre-padded image array.
// PARAMETERS
//  WIDTH   5  pixels per row; must be >= 2
//  HEIGHT  5  rows per frame; must be >= 2
//  PIX_W   8  bits per pixel
// PORTS
//  clk         in   1          rising-edge clock (single clock domain)
//  rst         in   1          synchronous, active-high reset
//  in_valid    in   1          in_data holds a valid pixel
//  in_ready    out  1          block accepts in_data this cycle (xfer = valid&ready)
//  in_data     in   PIX_W      pixel, raster order, frame start implied after reset/frame_done
//  out_valid   out  1          out_* hold a valid window
//  out_ready   in   1          downstream accepts window (xfer = valid&ready)
//  out_win     out  9*PIX_W    w[k] = out_win[k*PIX_W +: PIX_W], k=3*dr+dc, dr/dc 0..2 = top-left..bottom-right
//  out_row     out  $clog2(HEIGHT) centre row of window
//  out_col     out  $clog2(WIDTH)  centre column of window
//  out_last    out  1          window is (HEIGHT-1, WIDTH-1)
//  frame_done  out  1          1-cycle pulse the cycle after the last window transfers
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_win=0, out_row=0, out_col=0,
//    out_last=0, frame_done=0, in_ready=0 while rst high; ingest/emit counters
//    cleared. Applies mid-frame too: partial frame discarded, in_ready=1 the
//    first cycle after rst deasserts; buffer contents are don't-care.
//  - Storage: 3-row circular buffer, pixel (r,c) written to slot r mod 3.
//    Ingest counters (ir,ic); emit counters (er,ec).
//  - Window (er,ec) element (dr,dc) = pixel(clamp(er+dr-1,0,HEIGHT-1),
//    clamp(ec+dc-1,0,WIDTH-1)). Pixels passed unmodified; no arithmetic.
//  - Window (er,ec) is ready once pixel (min(er+1,HEIGHT-1), min(ec+1,WIDTH-1))
//    has been accepted. out_valid (registered) rises the cycle after the
//    enabling pixel transfer, or the cycle after the previous window transfers,
//    whichever is later. Sustained throughput 1 window/cycle.
//  - Output hold: while out_valid & !out_ready, all out_* stable.
//  - Flow control: in_ready=1 iff ir <= max(er+1,2) and frame not fully
//    ingested (prevents overwriting row er-1 still needed by row er).
//  - Frame end: in_ready=0 from transfer of pixel (HEIGHT-1,WIDTH-1) until the
//    out_last window transfers; then frame_done pulses, counters return to 0,
//    in_ready=1 the same cycle as the pulse. Exactly WIDTH*HEIGHT windows/frame.
//  - in_valid with in_ready=0: no transfer, pixel must be held by source.
// TESTING (WIDTH=HEIGHT=5, PIX_W=8, image rows 10,20,30,40,50 constant per row)
//  1. in_valid=1 continuous, out_ready=1 -> first out_valid the cycle after
//     pixel idx 6 transfers; (0,0) win={10,10,10,10,10,10,20,20,20}.
//  2. Same frame -> (4,4) win={40,40,40,50,50,50,50,50,50}, out_last=1,
//     frame_done next cycle; exactly 25 windows, raster row/col order.
//  3. out_ready=0 from start -> exactly 15 pixels accepted, then in_ready=0;
//     out_win for (0,0) stable; release -> all 25 windows in order.
//  4. Random in_valid/out_ready toggling, 2 back-to-back frames (2nd = 1..25
//     ramp) -> windows match clamped-index model; no loss/duplication.
//  5. rst pulse after 12 pixels -> out_valid=0 next cycle; fresh 25-pixel
//     frame afterwards produces correct 25 windows from (0,0).
//  6. Single-pixel-different image (centre=255, else 0) -> 255 appears at
//     k=8..0 positions exactly for windows centred at (1,1)..(3,3).

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Handshake bundle between a pixel source, sobel_window_gen and its 3x3 window sink.
interface sobel_window_gen_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned HEIGHT = 5,
  parameter int unsigned PIX_W  = 8
);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [PIX_W-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [9*PIX_W-1:0] out_win;
  logic [RW-1:0]      out_row;
  logic [CW-1:0]      out_col;
  logic               out_last;
  logic               frame_done;

  // Pixel source / window sink side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last, frame_done
  );

  // Window generator side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator with replicate-edge padding over a 3-row circular buffer.
module sobel_window_gen #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned HEIGHT = 5,
  parameter int unsigned PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  sobel_window_gen_if.slave bus
);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned XW = RW + 1;
  localparam int unsigned WW = 9 * PIX_W;
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_dec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  logic [PIX_W-1:0] line_buf [3][WIDTH];

  // Ingest position (next pixel expected) and emit position (next window to load)
  logic [RW-1:0] ir, er, ir_n, er_n;
  logic [CW-1:0] ic, ec, ic_n, ec_n;
  logic [1:0]    wslot, eslot, wslot_n, eslot_n;
  logic          in_done, emit_done, in_done_n, emit_done_n;

  logic          in_ready_q, out_valid_q, out_last_q, frame_done_q;
  logic [WW-1:0] out_win_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;

  logic          in_xfer, out_xfer, frame_end, win_avail, load, in_ready_n;
  logic [RW-1:0] need_r;
  logic [CW-1:0] need_c;
  logic [XW-1:0] row_lim;
  logic [1:0]    rows [3];
  logic [CW-1:0] cols [3];
  logic [WW-1:0] win_c;

  // Next-state for ingest/emit counters, window availability and window gather
  always_comb begin
    in_xfer     = bus.in_valid & in_ready_q;
    out_xfer    = out_valid_q & bus.out_ready;
    frame_end   = out_xfer & out_last_q;
    ir_n        = ir;
    ic_n        = ic;
    wslot_n     = wslot;
    in_done_n   = in_done;
    er_n        = er;
    ec_n        = ec;
    eslot_n     = eslot;
    emit_done_n = emit_done;
    win_c       = '0;

    if (in_xfer) begin
      if (ic == COL_LAST) begin
        if (ir == ROW_LAST) begin
          in_done_n = 1'b1;
        end else begin
          ic_n    = '0;
          ir_n    = ir + 1'b1;
          wslot_n = slot_inc(wslot);
        end
      end else begin
        ic_n = ic + 1'b1;
      end
    end

    // Window is available once its bottom-right (clamped) pixel is in, counting this cycle's transfer
    need_r    = (er == ROW_LAST) ? er : er + 1'b1;
    need_c    = (ec == COL_LAST) ? ec : ec + 1'b1;
    win_avail = !emit_done && (in_done_n || (ir_n > need_r) ||
                               ((ir_n == need_r) && (ic_n > need_c)));
    load      = win_avail && (!out_valid_q || bus.out_ready);

    if (load) begin
      if (ec == COL_LAST) begin
        ec_n = '0;
        if (er == ROW_LAST) begin
          emit_done_n = 1'b1;
        end else begin
          er_n    = er + 1'b1;
          eslot_n = slot_inc(eslot);
        end
      end else begin
        ec_n = ec + 1'b1;
      end
    end

    // Source row may run at most one row ahead of the row being emitted
    row_lim = XW'(er_n) + XW'(1);
    if (row_lim < XW'(2)) begin
      row_lim = XW'(2);
    end
    in_ready_n = !in_done_n && (XW'(ir_n) <= row_lim);

    // Clamped neighbourhood; the pixel being written this cycle is forwarded from the input
    rows[0] = (er == '0) ? eslot : slot_dec(eslot);
    rows[1] = eslot;
    rows[2] = (er == ROW_LAST) ? eslot : slot_inc(eslot);
    cols[0] = (ec == '0) ? ec : ec - 1'b1;
    cols[1] = ec;
    cols[2] = need_c;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if (in_xfer && (rows[dr] == wslot) && (cols[dc] == ic)) begin
          win_c[(3*dr+dc)*PIX_W +: PIX_W] = bus.in_data;
        end else begin
          win_c[(3*dr+dc)*PIX_W +: PIX_W] = line_buf[rows[dr]][cols[dc]];
        end
      end
    end
  end

  // Line buffer write; contents need no reset
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      line_buf[wslot][ic] <= bus.in_data;
    end
  end

  // Counter and output register update
  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= '0;
      ic           <= '0;
      er           <= '0;
      ec           <= '0;
      wslot        <= '0;
      eslot        <= '0;
      in_done      <= 1'b0;
      emit_done    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_win_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (frame_end) begin
      ir           <= '0;
      ic           <= '0;
      er           <= '0;
      ec           <= '0;
      wslot        <= '0;
      eslot        <= '0;
      in_done      <= 1'b0;
      emit_done    <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b1;
    end else begin
      ir           <= ir_n;
      ic           <= ic_n;
      er           <= er_n;
      ec           <= ec_n;
      wslot        <= wslot_n;
      eslot        <= eslot_n;
      in_done      <= in_done_n;
      emit_done    <= emit_done_n;
      in_ready_q   <= in_ready_n;
      frame_done_q <= 1'b0;
      if (load) begin
        out_valid_q <= 1'b1;
        out_win_q   <= win_c;
        out_row_q   <= er;
        out_col_q   <= ec;
        out_last_q  <= (er == ROW_LAST) && (ec == COL_LAST);
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_win    = out_win_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised self-checking bench for sobel_window_gen against a clamped-index image model.
module tb_sobel_window_gen;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 8;
  localparam int NP = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) bus ();
  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int img [NP];
  logic [71:0] got_win [NP];

  // Reference window: every tap reads the image at the edge-clamped coordinate
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    int rr, cc;
    w = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        w[(3*dr+dc)*8 +: 8] = 8'(img[rr*W+cc]);
      end
    end
    return w;
  endfunction

  function automatic void load_rows();
    for (int i = 0; i < NP; i++) img[i] = 10 * (i / W + 1);
  endfunction

  function automatic void load_ramp();
    for (int i = 0; i < NP; i++) img[i] = i + 1;
  endfunction

  // Stream one frame with random stalls (pv/pr percent), optional initial out_ready hold-off
  task automatic run_frame(input int pv, input int pr, input int stall);
    int np, nw, cyc;
    bit seen_valid, done_next, holding, finished;
    logic [71:0] h_win, e_win;
    logic [2:0] h_row, h_col;
    logic h_last;
    np = 0; nw = 0; cyc = 0;
    seen_valid = 0; done_next = 0; holding = 0; finished = 0;
    h_win = '0; h_row = '0; h_col = '0; h_last = 1'b0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_timeout: pixels %0d windows %0d, required %0d/%0d", np, nw, NP, NP);
        bus.in_valid = 1'b0;
        break;
      end
      n_cmp++;
      if (bus.frame_done !== done_next) begin
        n_bad++;
        $display("FAIL frame_done: got %b required %b after %0d windows", bus.frame_done, done_next, nw);
      end
      if (done_next) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL in_ready_at_done: got %b required 1", bus.in_ready);
        end
        n_cmp++;
        if (np != NP || nw != NP) begin
          n_bad++;
          $display("FAIL frame_counts: pixels %0d windows %0d required %0d/%0d", np, nw, NP, NP);
        end
        finished = 1;
      end
      if (holding) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_win, bus.out_row, bus.out_col, bus.out_last} !==
            {1'b1, h_win, h_row, h_col, h_last}) begin
          n_bad++;
          $display("FAIL hold: got v=%b win=%h r=%0d c=%0d required v=1 win=%h r=%0d c=%0d",
                   bus.out_valid, bus.out_win, bus.out_row, bus.out_col, h_win, h_row, h_col);
        end
      end
      if (bus.out_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        n_cmp++;
        if (np != W + 2) begin
          n_bad++;
          $display("FAIL first_window_latency: pixels accepted %0d required %0d", np, W + 2);
        end
      end
      if (np == NP && !done_next) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL in_ready_after_last_pixel: got %b required 0", bus.in_ready);
        end
      end
      if (stall > 0 && cyc == stall) begin
        n_cmp++;
        if (np != 3 * W || bus.in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_accept: pixels %0d in_ready %b required %0d and 0", np, bus.in_ready, 3 * W);
        end
      end
      if (finished) begin
        bus.in_valid = 1'b0;
        break;
      end

      bus.in_valid  = (np < NP) && (int'($urandom_range(99)) < pv);
      bus.in_data   = 8'(img[(np < NP) ? np : NP - 1]);
      bus.out_ready = (stall > 0 && cyc <= stall) ? 1'b0 : (int'($urandom_range(99)) < pr);

      if (bus.in_valid && bus.in_ready === 1'b1) np++;
      holding = 0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          n_cmp++;
          if (nw >= NP) begin
            n_bad++;
            $display("FAIL extra_window: got window %0d required at most %0d", nw + 1, NP);
          end else begin
            e_win = exp_win(nw / W, nw % W);
            if (bus.out_win !== e_win || bus.out_row !== 3'(nw / W) ||
                bus.out_col !== 3'(nw % W) || bus.out_last !== (nw == NP - 1)) begin
              n_bad++;
              $display("FAIL window_%0d: got win=%h r=%0d c=%0d last=%b required win=%h r=%0d c=%0d last=%b",
                       nw, bus.out_win, bus.out_row, bus.out_col, bus.out_last,
                       e_win, nw / W, nw % W, (nw == NP - 1));
            end
            got_win[nw] = bus.out_win;
            if (nw == NP - 1) done_next = 1;
          end
          nw++;
        end else begin
          holding = 1;
          h_win = bus.out_win; h_row = bus.out_row; h_col = bus.out_col; h_last = bus.out_last;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.frame_done, bus.in_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got v=%b last=%b done=%b rdy=%b required all 0",
               bus.out_valid, bus.out_last, bus.frame_done, bus.in_ready);
    end
    n_cmp++;
    if (bus.out_win !== 72'h0 || bus.out_row !== 3'd0 || bus.out_col !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_data: got win=%h r=%0d c=%0d required 0", bus.out_win, bus.out_row, bus.out_col);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    int v0 [9] = '{10, 10, 10, 10, 10, 10, 20, 20, 20};
    int v1 [9] = '{40, 40, 40, 50, 50, 50, 50, 50, 50};
    logic [71:0] e0, e1;
    for (int k = 0; k < 9; k++) begin
      e0[k*8 +: 8] = 8'(v0[k]);
      e1[k*8 +: 8] = 8'(v1[k]);
    end
    load_rows();
    run_frame(100, 100, 0);
    n_cmp++;
    if (got_win[0] !== e0) begin
      n_bad++;
      $display("FAIL stream_first_window: got %h required %h", got_win[0], e0);
    end
    n_cmp++;
    if (got_win[NP-1] !== e1) begin
      n_bad++;
      $display("FAIL stream_last_window: got %h required %h", got_win[NP-1], e1);
    end
  endtask

  task automatic test_backpressure();
    load_rows();
    run_frame(100, 100, 40);
  endtask

  task automatic test_back_to_back();
    load_rows();
    run_frame(60, 50, 0);
    load_ramp();
    run_frame(70, 40, 0);
  endtask

  task automatic test_mid_reset();
    int np, cyc;
    np = 0; cyc = 0;
    load_rows();
    bus.out_ready = 1'b1;
    while (np < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b1;
      bus.in_data = 8'(img[np]);
      if (bus.in_ready === 1'b1) np++;
    end
    n_cmp++;
    if (np != 12) begin
      n_bad++;
      $display("FAIL mid_reset_feed: got %0d pixels required 12", np);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.frame_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got v=%b rdy=%b done=%b required 0", bus.out_valid, bus.in_ready, bus.frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_release: got rdy=%b v=%b required 1 and 0", bus.in_ready, bus.out_valid);
    end
    load_ramp();
    run_frame(100, 100, 0);
  endtask

  task automatic test_single_pixel();
    logic [71:0] e;
    int r, c;
    for (int i = 0; i < NP; i++) img[i] = 0;
    img[2*W+2] = 255;
    run_frame(80, 80, 0);
    for (int n = 0; n < NP; n++) begin
      r = n / W;
      c = n % W;
      e = '0;
      if (r >= 1 && r <= 3 && c >= 1 && c <= 3) e[(3*(3-r)+(3-c))*8 +: 8] = 8'hff;
      n_cmp++;
      if (got_win[n] !== e) begin
        n_bad++;
        $display("FAIL single_pixel_(%0d,%0d): got %h required %h", r, c, got_win[n], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_single_pixel();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
